// File: rtl/segment_reader.sv
// segment_reader: recovers BCD digits and decimal points from a multiplexed,
// active-low 7-segment display bus. A digit slot is captured once its pattern
// has been stable for STABLE_CYCLES consecutive samples; unknown patterns are
// reported through pattern_error instead of being decoded.
module segment_reader #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            segments,
    input  logic [DIGITS-1:0]     anodes,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  frame_valid,
    output logic                  frame_strobe,
    output logic                  pattern_error,
    output logic [2:0]            error_digit
);

    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_HELD
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_an;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_arm;

    logic [DIGITS-1:0]   w_an_low;
    logic [3:0]          w_in_zeros;
    logic                w_in_sel;
    logic                w_same;
    logic                w_capture;
    logic [DIGITS-1:0]   w_hot;
    logic [3:0]          w_digit;
    logic                w_dec_ok;
    logic [2:0]          w_err_idx;
    logic [4*DIGITS-1:0] w_value_nxt;
    logic [DIGITS-1:0]   w_dp_nxt;
    logic [DIGITS-1:0]   w_valid_nxt;

    assign w_an_low = ~anodes;
    assign w_hot    = ~r_an;
    assign w_same   = ({segments, anodes} == {r_seg, r_an});

    // Incoming sample is selectable only with exactly one digit enabled
    always_comb begin
        w_in_zeros = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_in_zeros = w_in_zeros + 4'(w_an_low[i]);
        end
        w_in_sel = (w_in_zeros == 4'd1);
    end

    // Sample registers and stability counter advance together on every edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= '1;
            r_an  <= '1;
            r_cnt <= '0;
        end else begin
            r_seg <= segments;
            r_an  <= anodes;
            if (!w_in_sel) begin
                r_cnt <= '0;
            end else if (!w_same) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt < STABLE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Segment pattern decode of the registered sample
    always_comb begin
        w_dec_ok = 1'b1;
        w_digit  = 4'd0;
        case (r_seg[6:0])
            7'b1000000: w_digit = 4'd0;
            7'b1111001: w_digit = 4'd1;
            7'b0100100: w_digit = 4'd2;
            7'b0110000: w_digit = 4'd3;
            7'b0011001: w_digit = 4'd4;
            7'b0010010: w_digit = 4'd5;
            7'b0000010: w_digit = 4'd6;
            7'b1111000: w_digit = 4'd7;
            7'b0000000: w_digit = 4'd8;
            7'b0011000: w_digit = 4'd9;
            default:    w_dec_ok = 1'b0;
        endcase
    end

    // Frame contents as they would look after capturing the current sample
    always_comb begin
        w_value_nxt = value;
        w_dp_nxt    = dp;
        w_valid_nxt = digit_valid;
        w_err_idx   = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_hot[i]) begin
                w_err_idx      = 3'(i);
                w_dp_nxt[i]    = ~r_seg[7];
                w_valid_nxt[i] = w_dec_ok;
                if (w_dec_ok) begin
                    w_value_nxt[4*i +: 4] = w_digit;
                end
            end
        end
    end

    // Capture FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture FSM next state; a counter value of 1..STABLE-1 means a fresh pattern
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_cnt != '0) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == STABLE) begin
                    w_state_nxt = ST_CAPTURE;
                    w_capture   = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt != STABLE) begin
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt != STABLE) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Captured frame, status flags and one-cycle pulses; clear overrides capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value         <= '0;
            dp            <= '0;
            digit_valid   <= '0;
            frame_valid   <= 1'b0;
            frame_strobe  <= 1'b0;
            pattern_error <= 1'b0;
            error_digit   <= 3'd0;
            r_arm         <= 1'b0;
        end else begin
            pattern_error <= 1'b0;
            r_arm         <= 1'b0;
            frame_strobe  <= r_arm;
            if (clear) begin
                value       <= '0;
                dp          <= '0;
                digit_valid <= '0;
                frame_valid <= 1'b0;
            end else if (w_capture) begin
                value       <= w_value_nxt;
                dp          <= w_dp_nxt;
                digit_valid <= w_valid_nxt;
                frame_valid <= &w_valid_nxt;
                if (w_dec_ok) begin
                    r_arm <= w_hot[DIGITS-1] & (&w_valid_nxt);
                end else begin
                    pattern_error <= 1'b1;
                    error_digit   <= w_err_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_segment_reader.sv
// Self-checking bench for segment_reader: directed vector table, hand-written
// reset/latency sequence, and randomized traffic against a run-length model.
module tb_segment_reader;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned STABLE = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [7:0]           segments;
    logic [DIGITS-1:0]    anodes;
    logic                 clear;
    logic [4*DIGITS-1:0]  value;
    logic [DIGITS-1:0]    dp;
    logic [DIGITS-1:0]    digit_valid;
    logic                 frame_valid;
    logic                 frame_strobe;
    logic                 pattern_error;
    logic [2:0]           error_digit;

    segment_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .segments     (segments),
        .anodes       (anodes),
        .clear        (clear),
        .value        (value),
        .dp           (dp),
        .digit_valid  (digit_valid),
        .frame_valid  (frame_valid),
        .frame_strobe (frame_strobe),
        .pattern_error(pattern_error),
        .error_digit  (error_digit)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int strb_seen = 0;

    logic [6:0] pat_tbl [10];

    // Reference model: run length of identical selectable samples
    logic [7:0]        m_prev_seg;
    logic [DIGITS-1:0] m_prev_an;
    int                m_run;
    bit                m_pend;
    logic [7:0]        m_pend_seg;
    int                m_pend_idx;
    bit                m_arm;
    logic [3:0]        m_val [DIGITS];
    bit                m_dp  [DIGITS];
    bit                m_ok  [DIGITS];
    bit                m_err;
    int                m_errd;
    bit                m_strobe;

    typedef struct {
        logic [7:0]        seg;
        logic [DIGITS-1:0] an;
        logic              clr;
        int                cycles;
        logic [15:0]       exp_val;
        logic [3:0]        exp_dp;
        logic [3:0]        exp_ok;
    } vec_t;

    vec_t vecs [12];

    function automatic int decode(input logic [6:0] p);
        int r;
        r = -1;
        for (int k = 0; k < 10; k++) begin
            if (pat_tbl[k] == p) r = k;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_prev_seg = '1;
        m_prev_an  = '1;
        m_run      = 0;
        m_pend     = 0;
        m_pend_seg = '1;
        m_pend_idx = 0;
        m_arm      = 0;
        m_err      = 0;
        m_errd     = 0;
        m_strobe   = 0;
        for (int i = 0; i < DIGITS; i++) begin
            m_val[i] = 4'd0;
            m_dp[i]  = 0;
            m_ok[i]  = 0;
        end
    endtask

    task automatic model_edge(input logic [7:0] seg, input logic [DIGITS-1:0] an, input logic clr);
        int d;
        bit others;
        m_strobe = m_arm;
        m_arm    = 0;
        m_err    = 0;
        if (m_pend && !clr) begin
            d = decode(m_pend_seg[6:0]);
            m_dp[m_pend_idx] = ~m_pend_seg[7];
            if (d >= 0) begin
                others = 1;
                for (int j = 0; j < DIGITS - 1; j++) others = others & m_ok[j];
                m_arm = (m_pend_idx == DIGITS - 1) && others;
                m_val[m_pend_idx] = 4'(d);
                m_ok[m_pend_idx]  = 1;
            end else begin
                m_ok[m_pend_idx] = 0;
                m_err  = 1;
                m_errd = m_pend_idx;
            end
        end
        if (clr) begin
            for (int i = 0; i < DIGITS; i++) begin
                m_val[i] = 4'd0;
                m_dp[i]  = 0;
                m_ok[i]  = 0;
            end
        end
        if ($countones(~an) != 1) m_run = 0;
        else if (seg == m_prev_seg && an == m_prev_an) m_run = m_run + 1;
        else m_run = 1;
        m_pend = (m_run == STABLE);
        if (m_pend) begin
            m_pend_seg = seg;
            for (int i = 0; i < DIGITS; i++) if (!an[i]) m_pend_idx = i;
        end
        m_prev_seg = seg;
        m_prev_an  = an;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [4*DIGITS-1:0] ev;
        logic [DIGITS-1:0]   ed;
        logic [DIGITS-1:0]   eo;
        for (int i = 0; i < DIGITS; i++) begin
            ev[4*i +: 4] = m_val[i];
            ed[i] = m_dp[i];
            eo[i] = m_ok[i];
        end
        check("value",         32'(value),         32'(ev));
        check("dp",            32'(dp),            32'(ed));
        check("digit_valid",   32'(digit_valid),   32'(eo));
        check("frame_valid",   32'(frame_valid),   32'(&eo));
        check("frame_strobe",  32'(frame_strobe),  32'(m_strobe));
        check("pattern_error", 32'(pattern_error), 32'(m_err));
        check("error_digit",   32'(error_digit),   32'(m_errd));
    endtask

    task automatic step(input logic [7:0] seg, input logic [DIGITS-1:0] an, input logic clr);
        segments = seg;
        anodes   = an;
        clear    = clr;
        @(posedge clk);
        model_edge(seg, an, clr);
        #1;
        compare_all();
        if (pattern_error) err_seen++;
        if (frame_strobe) strb_seen++;
    endtask

    initial begin
        pat_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

        vecs[0]  = '{8'hFF, 4'b1111, 1'b0, 8,  16'h0000, 4'b0000, 4'b0000};
        vecs[1]  = '{8'h40, 4'b1110, 1'b0, 6,  16'h0000, 4'b0001, 4'b0001};
        vecs[2]  = '{8'hF9, 4'b1101, 1'b0, 6,  16'h0010, 4'b0001, 4'b0011};
        vecs[3]  = '{8'hA4, 4'b1011, 1'b0, 6,  16'h0210, 4'b0001, 4'b0111};
        vecs[4]  = '{8'hB0, 4'b0111, 1'b0, 6,  16'h3210, 4'b0001, 4'b1111};
        vecs[5]  = '{8'h99, 4'b1011, 1'b0, 3,  16'h3210, 4'b0001, 4'b1111};
        vecs[6]  = '{8'h92, 4'b1011, 1'b0, 6,  16'h3510, 4'b0001, 4'b1111};
        vecs[7]  = '{8'hFF, 4'b1101, 1'b0, 6,  16'h3510, 4'b0001, 4'b1101};
        vecs[8]  = '{8'h40, 4'b1100, 1'b0, 10, 16'h3510, 4'b0001, 4'b1101};
        vecs[9]  = '{8'h40, 4'b1110, 1'b0, 4,  16'h3510, 4'b0001, 4'b1101};
        vecs[10] = '{8'h40, 4'b1110, 1'b1, 1,  16'h0000, 4'b0000, 4'b0000};
        vecs[11] = '{8'h40, 4'b1110, 1'b0, 4,  16'h0000, 4'b0000, 4'b0000};

        // Power-on reset with a blank bus
        rst_n    = 1'b0;
        segments = 8'hFF;
        anodes   = '1;
        clear    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        check("reset_value", 32'(value), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int v = 0; v < 12; v++) begin
            for (int c = 0; c < vecs[v].cycles; c++) step(vecs[v].seg, vecs[v].an, vecs[v].clr);
            check($sformatf("vec%0d_value", v), 32'(value), 32'(vecs[v].exp_val));
            check($sformatf("vec%0d_dp", v), 32'(dp), 32'(vecs[v].exp_dp));
            check($sformatf("vec%0d_valid", v), 32'(digit_valid), 32'(vecs[v].exp_ok));
            check($sformatf("vec%0d_frame", v), 32'(frame_valid), 32'(&vecs[v].exp_ok));
        end
        check("error_pulses", 32'(err_seen), 32'd1);
        check("strobe_pulses", 32'(strb_seen), 32'd1);
        check("error_digit_held", 32'(error_digit), 32'd1);

        // Reset during SETTLE of digit 3, then full latency again
        for (int c = 0; c < 6; c++) step(8'h79, 4'b1110, 1'b0);
        check("pre_reset_nibble0", 32'(value[3:0]), 32'd1);
        for (int c = 0; c < 2; c++) step(8'h30, 4'b0111, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("async_reset_value", 32'(value), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(8'h30, 4'b0111, 1'b0);
            check($sformatf("relatency_k%0d", k), 32'(digit_valid[3]), (k >= STABLE) ? 32'd1 : 32'd0);
        end

        // Randomized traffic against the model
        for (int r = 0; r < 500; r++) begin
            logic [7:0]        seg;
            logic [DIGITS-1:0] an;
            int                hold;
            int                sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 7) an = ~(4'b0001 << $urandom_range(0, DIGITS - 1));
            else if (sel == 7) an = '1;
            else an = 4'($urandom);
            if ($urandom_range(0, 5) != 0) seg = {1'($urandom), pat_tbl[$urandom_range(0, 9)]};
            else seg = 8'($urandom);
            hold = int'($urandom_range(1, 7));
            for (int h = 0; h < hold; h++) step(seg, an, ($urandom_range(0, 39) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/segment_reader.md
# segment_reader

Decodes a time-multiplexed, active-low 7-segment display bus (shared segment lines plus per-digit anode enables) back into BCD digits and decimal-point flags. It is the receive-side counterpart of the display encoder: it sits on the display bus as a loopback checker and board-level monitor, and recovers what is being shown as a multi-digit value. Each digit slot is captured only after its pattern has been stable for a programmable number of cycles. Unrecognised patterns are flagged, never guessed.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digit positions (1..8)
- STABLE_CYCLES, 4, consecutive identical samples required before capture (2..255)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- segments  input  8  active-low segment bus; bit7 = DP, bits[6:0] = g,f,e,d,c,b,a
- anodes  input  DIGITS  active-low digit enables; bit i selects digit i
- clear  input  1  synchronous clear of captured frame
- value  output  4*DIGITS  decoded BCD; nibble i (bits 4i+3:4i) = digit i
- dp  output  DIGITS  captured decimal point per digit, 1 = lit
- digit_valid  output  DIGITS  digit i holds a valid decode
- frame_valid  output  1  AND of all digit_valid bits
- frame_strobe  output  1  one-cycle pulse when a frame completes
- pattern_error  output  1  one-cycle pulse on an unrecognised pattern
- error_digit  output  3  index of the last digit that raised pattern_error

## Operation
- Input stage: segments and anodes are registered every cycle (sample). The decision logic uses only registered samples.
- Select check: a sample is selectable only when exactly one anodes bit is 0. All-ones (blanking) or multiple zeros are non-selectable.
- Stability counter (8 bits):
  - Set to 1 when a selectable sample differs from the previous sample in any bit.
  - Incremented (saturating at STABLE_CYCLES) when the sample equals the previous one.
  - Forced to 0 on a non-selectable sample.
- FSM:
  - IDLE: no selectable sample. Goes to SETTLE on a selectable sample.
  - SETTLE: counting. Goes to CAPTURE when the counter reaches STABLE_CYCLES. Returns to IDLE on a non-selectable sample. Stays in SETTLE (counter reloads to 1) when the sample changes.
  - CAPTURE: one cycle; writes the result. Goes to HELD.
  - HELD: waits. Goes to SETTLE on any sample change, or to IDLE on a non-selectable sample. A held pattern is never captured twice.
- Decode uses bits[6:0] only:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0011000=9.
  - Every other pattern is invalid.
  - dp = ~segments[7], captured regardless of decode result.
- Valid capture of digit i: write nibble i, write dp[i], set digit_valid[i].
- Invalid capture of digit i:
  - Nibble i is unchanged.
  - dp[i] is updated.
  - digit_valid[i] is cleared.
  - pattern_error pulses; error_digit = i.
- frame_strobe: pulses in the cycle after a valid capture of digit DIGITS-1, if all other digit_valid bits are already 1.
- clear: zeroes value, dp and digit_valid. It does not affect the FSM or the counter. If clear and a capture occur in the same cycle, clear wins and the capture is discarded.

## Timing
- Reset values: value=0, dp=0, digit_valid=0, frame_valid=0, frame_strobe=0, pattern_error=0, error_digit=0. FSM in IDLE, counter=0, sample registers = all-ones (blank).
- Reset asserted mid-capture: all state returns to the reset values immediately. No partial write survives.
- Latency: a pattern first sampled at edge 0 and held reaches the counter value STABLE_CYCLES at edge STABLE_CYCLES-1. The value, dp, digit_valid and pattern_error updates are visible after edge STABLE_CYCLES.
- frame_valid is registered with digit_valid. frame_strobe is visible one edge after the digit_valid update.
- Pulse width: pattern_error and frame_strobe are exactly one cycle wide, even while the pattern is held.
- A change arriving in the same cycle the counter would hit STABLE_CYCLES aborts the capture and restarts the count at 1.
- A glitch of fewer than STABLE_CYCLES samples produces no capture.

## Test plan
- Reset / no activity: deassert rst_n and hold anodes=1111. Outputs must stay at their reset values; no pulses.
- Stable digits, STABLE_CYCLES=4: scan digits 0..3 with patterns 0x40, 0xF9, 0xA4, 0xB0, each held 6 cycles. Required: value=16'h3210, dp=4'b0001, frame_valid=1, and one frame_strobe in the cycle after digit 3's update.
- Glitch rejection: set digit 2 to 0x99 for 3 cycles, then 0x92 for 6 cycles. Required: nibble 2 = 5, no capture of 4, update after the 4th stable sample of 0x92.
- Invalid pattern: drive digit 1 with 0xFF for 6 cycles. Required: one pattern_error pulse, error_digit=1, digit_valid[1]=0, nibble 1 unchanged, frame_valid=0.
- Bad select and clear: drive anodes=1100 for 10 cycles; no capture is allowed. Then assert clear in the same cycle as a digit-0 capture. Required: all outputs zero and digit_valid[0]=0.
- Mid-operation reset: pulse rst_n low during SETTLE of digit 3. Required: all outputs return to zero asynchronously; the next capture needs a full STABLE_CYCLES again.
